serial_subtractor_nbit: RTL

- Bit-serial N-bit subtractor with a start/done handshake. Computes difference = a - b - borrow_in, one bit per clock, LSB first.
- It is the inverse operation to the combinational adder_4bit datapath and sits beside it in the arithmetic library.
- It trades latency for area and gives the lab flow a sequential arithmetic block with FSM, counter and shift registers.

---
 rtl/serial_subtractor_nbit.sv | 97 +++++++++
 1 files changed

// File: rtl/serial_subtractor_nbit.sv
// Bit-serial N-bit subtractor: difference = a - b - borrow_in, one bit per clock, LSB first.
// A start/done handshake wraps the bit loop. difference and underflow stay registered until the next completion.
module serial_subtractor_nbit #(
  parameter int NUM_BITS = 4
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start,
  input  logic [NUM_BITS-1:0] a,
  input  logic [NUM_BITS-1:0] b,
  input  logic                borrow_in,
  output logic                busy,
  output logic                done,
  output logic [NUM_BITS-1:0] difference,
  output logic                underflow
);

  localparam int CNT_W = (NUM_BITS > 2) ? $clog2(NUM_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NUM_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    bit_cnt;
  logic [NUM_BITS-1:0] a_sr;
  logic [NUM_BITS-1:0] b_sr;
  logic [NUM_BITS-1:0] res_sr;
  logic                br;

  logic ai;
  logic bi;
  logic d;
  logic br_next;

  // One full-subtractor cell acting on the current LSB pair and the running borrow
  assign ai      = a_sr[0];
  assign bi      = b_sr[0];
  assign d       = ai ^ bi ^ br;
  assign br_next = (~ai & bi) | (~(ai ^ bi) & br);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      br         <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      difference <= '0;
      underflow  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sr    <= a;
            b_sr    <= b;
            br      <= borrow_in;
            bit_cnt <= '0;
            res_sr  <= '0;
            busy    <= 1'b1;
            state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          // The result fills from the MSB end, so after NUM_BITS shifts bit 0 lands at the LSB
          a_sr    <= {1'b0, a_sr[NUM_BITS-1:1]};
          b_sr    <= {1'b0, b_sr[NUM_BITS-1:1]};
          res_sr  <= {d, res_sr[NUM_BITS-1:1]};
          br      <= br_next;
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) begin
            difference <= {d, res_sr[NUM_BITS-1:1]};
            underflow  <= br_next;
            done       <= 1'b1;
            state      <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
